oam_dma_arbiter: RTL

//  Sprite (OAM) DMA engine and memory-bus arbiter between cpu and system bus.
//  - Detects a CPU write to the DMA page register; halts the CPU via ready.
//  - Owns the bus to copy XFER_LEN bytes from {page,8'h00} to DEST_ADDR.
//  - Releases the bus; when idle, CPU bus signals pass straight through.

---
 rtl/oam_dma_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
//   Sprite (OAM) DMA engine and memory-bus arbiter between the CPU and the
//   system bus. A CPU write to DMA_REG_ADDR latches a source page and halts
//   the CPU. The engine then copies XFER_LEN bytes from {page,8'h00} to the
//   fixed DEST_ADDR, one read cycle and one write cycle per byte. It then
//   hands the bus back to the CPU. While idle, the CPU bus signals pass
//   straight through to the system bus.
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   When defined, HALT goes to an extra ALIGN cycle if the free-running
//   parity bit is 1.
//   When undefined, the ALIGN state does not exist and HALT always goes
//   to READ.
//
// Ports
//   clk        in   1   system clock, all logic on posedge
//   reset      in   1   synchronous active-low reset
//   cpu_addr   in   16  CPU address
//   cpu_d_out  in   8   CPU write data
//   cpu_write  in   1   CPU write strobe
//   cpu_ready  out  1   CPU ready, 0 = CPU halted (registered)
//   bus_d_in   in   8   read data from the system bus
//   bus_addr   out  16  system bus address
//   bus_d_out  out  8   system bus write data
//   bus_write  out  1   system bus write strobe
//   dma_active out  1   engine owns the bus (READ/WRITE), registered
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic        cpu_ready,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
`ifdef OAM_DMA_ALIGN_EN
    ST_ALIGN = 3'd2,
`endif
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       parity_q;
  logic       cpu_ready_q;
  logic       dma_active_q;

`ifndef OAM_DMA_ALIGN_EN
  // Parity only steers the ALIGN decision. This keeps it visibly consumed
  // in the default build.
  logic parity_unused_s;
  assign parity_unused_s = parity_q;
`endif

  // Next-state, page, index and read-latch logic.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_d_out;
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        if (parity_q) begin
          state_d = ST_ALIGN;
        end else begin
          state_d = ST_READ;
        end
`else
        state_d = ST_READ;
`endif
      end
`ifdef OAM_DMA_ALIGN_EN
      ST_ALIGN: state_d = ST_READ;
`endif
      ST_READ: begin
        latch_d = bus_d_in;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // idx is 8 bits wide and never carries into page.
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. The ready and active flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      latch_q      <= 8'h00;
      parity_q     <= 1'b0;
      cpu_ready_q  <= 1'b1;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      latch_q      <= latch_d;
      parity_q     <= ~parity_q;
      cpu_ready_q  <= (state_d == ST_IDLE);
      dma_active_q <= (state_d == ST_READ) || (state_d == ST_WRITE);
    end
  end

  // Bus multiplexer: CPU passthrough when idle, CPU writes masked while halted.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus_addr  = cpu_addr;
        bus_d_out = cpu_d_out;
        bus_write = cpu_write;
      end
      ST_READ: begin
        bus_addr  = {page_q, idx_q};
        bus_d_out = latch_q;
        bus_write = 1'b0;
      end
      ST_WRITE: begin
        bus_addr  = DEST_ADDR;
        bus_d_out = latch_q;
        bus_write = 1'b1;
      end
      default: begin
        // HALT / ALIGN: CPU address visible, writes suppressed.
        bus_addr  = cpu_addr;
        bus_d_out = cpu_d_out;
        bus_write = 1'b0;
      end
    endcase
  end

  assign cpu_ready  = cpu_ready_q;
  assign dma_active = dma_active_q;

endmodule
